// File: rtl/hs_mem_pkg.sv
// Shared definitions for the simple dual-port RAM helpers: burst-reader FSM
// encoding, output buffer sizing and the address-wrap step.
package hs_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } hs_mem_rd_burst_state_e;

   localparam int HS_MEM_RD_OBUF_DEPTH = 3;
   localparam int HS_MEM_RD_OBUF_CW    = $clog2(HS_MEM_RD_OBUF_DEPTH + 1);

   // Next sequential address; wraps at depth so non-power-of-2 RAMs work.
   function automatic int unsigned hs_mem_next_addr(input int unsigned addr,
                                                    input int unsigned depth);
      return (addr >= depth - 1) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/hs_mem_rd_obuf.sv
// Three-entry register FIFO holding RAM read data plus its last-beat tag.
// Count and empty are registered so downstream issue logic sees no rsp_ready path.
module hs_mem_rd_obuf
   import hs_mem_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [HS_MEM_RD_OBUF_CW-1:0] count,
   output logic                         empty
);

   localparam int DEPTH = HS_MEM_RD_OBUF_DEPTH;
   localparam int PW    = $clog2(DEPTH);

   logic [WIDTH-1:0]             mem_q [DEPTH];
   logic [PW-1:0]                wr_ptr_q;
   logic [PW-1:0]                rd_ptr_q;
   logic [HS_MEM_RD_OBUF_CW-1:0] count_q;
   logic [HS_MEM_RD_OBUF_CW-1:0] count_d;
   logic                         empty_q;
   logic                         full;
   logic                         do_push;
   logic                         do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign full    = (int'(count_q) == DEPTH);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         count_q <= count_d;
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = empty_q;

`ifndef SYNTHESIS
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full));
`endif

endmodule

// File: rtl/hs_mem_rd_burst.sv
// Burst read engine for a latency-1 RAM read port: sequential reads out,
// valid/ready beat stream back, with a small buffer absorbing backpressure.
module hs_mem_rd_burst
   import hs_mem_pkg::*;
#(
   parameter type DATA_TYPE  = logic [7:0],
   parameter int  DATA_DEPTH = 16,
   parameter int  MAX_BURST  = 16,
   localparam int ADDR_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
   localparam int LEN_WIDTH  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  req_valid,
   output logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic                  ram_ren,
   input  DATA_TYPE              ram_rdata,
   output DATA_TYPE              rsp_data,
   output logic                  rsp_last,
   output logic                  rsp_valid,
   input  logic                  rsp_ready
);

   localparam int DW = $bits(DATA_TYPE);

   // Handshakes: a transfer happens on a rising edge where valid && ready are
   // both high; valid never waits on ready, and payload holds while stalled.
   hs_mem_rd_burst_state_e       state_q;
   logic [ADDR_WIDTH-1:0]        addr_q;
   logic [LEN_WIDTH-1:0]         remain_q;
   logic                         inflight_q;
   logic                         inflight_last_q;
   logic                         req_fire;
   logic                         issue;
   logic                         issue_last;
   logic                         rsp_fire;
   logic [HS_MEM_RD_OBUF_CW-1:0] buf_count;
   logic                         buf_empty;
   logic [DW:0]                  buf_head;

   assign req_ready = (state_q == IDLE);
   assign req_fire  = req_valid && req_ready;

   // Slots reserved for reads already in flight keep the buffer from overflowing.
   assign issue      = (state_q == ISSUE) &&
                       ((int'(buf_count) + int'(inflight_q)) < HS_MEM_RD_OBUF_DEPTH);
   assign issue_last = issue && (remain_q == '0);

   assign ram_ren   = issue;
   assign ram_raddr = addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= issue_last;
         if (req_fire) begin
            addr_q   <= req_addr;
            remain_q <= req_len;
         end else if (issue) begin
            addr_q   <= ADDR_WIDTH'(hs_mem_next_addr(32'(addr_q), 32'(DATA_DEPTH)));
            remain_q <= remain_q - 1'b1;
         end
         case (state_q)
            IDLE:    if (req_fire) state_q <= ISSUE;
            ISSUE:   if (issue_last) state_q <= DRAIN;
            DRAIN:   if (!inflight_q && buf_empty) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_fire = rsp_valid && rsp_ready;

   hs_mem_rd_obuf #(
      .WIDTH(DW + 1)
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({inflight_last_q, ram_rdata}),
      .pop       (rsp_fire),
      .head_data (buf_head),
      .count     (buf_count),
      .empty     (buf_empty)
   );

   assign rsp_valid = !buf_empty;
   assign rsp_data  = DATA_TYPE'(buf_head[DW-1:0]);
   assign rsp_last  = buf_head[DW] && !buf_empty;

`ifndef SYNTHESIS
   a_req_len_range: assert property (@(posedge clk) disable iff (!rst_n)
      req_fire |-> (32'(req_len) < 32'(MAX_BURST)));

   a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_last)));
`endif

endmodule
